// File: rtl/branch_resolve_unit_if.sv
// EXE-stage control-flow fields, redirect back to IF/ID, and the fetch-side
// BTB lookup port of the branch resolve unit.
interface branch_resolve_unit_if;
  logic        en;
  logic [31:0] pc;
  logic        jal;
  logic        jalr;
  logic        beq;
  logic        bne;
  logic        bge;
  logic        predict_jump;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [31:0] imm_I_S;
  logic [31:0] imm_B;
  logic [31:0] imm_J;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic        if_predict;
  logic [31:0] if_predict_pc;

  modport master (
    output en, pc, jal, jalr, beq, bne, bge, predict_jump,
           r1, r2, imm_I_S, imm_B, imm_J, if_pc,
    input  redirect, redirect_pc, if_predict, if_predict_pc
  );

  modport slave (
    input  en, pc, jal, jalr, beq, bne, bge, predict_jump,
           r1, r2, imm_I_S, imm_B, imm_J, if_pc,
    output redirect, redirect_pc, if_predict, if_predict_pc
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves EXE-stage control flow, issues redirects on misprediction and
// trains the BTB (2-bit counters) that supplies the fetch-stage prediction.
module branch_resolve_unit #(
  parameter int BTB_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispredict_cnt
);
  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              btb_valid  [ENTRIES];
  logic [1:0]        btb_ctr    [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [31:0]       btb_target [ENTRIES];

  logic signed [31:0]   r1_s, r2_s;
  logic                 is_br, taken, upd, exe_hit;
  logic [31:0]          target, fall_pc;
  logic [BTB_IDX_W-1:0] exe_idx, if_idx;
  logic [TAG_W-1:0]     exe_tag, if_tag;
  logic                 if_hit;
  logic [1:0]           unused_if_pc;

  assign r1_s         = bus.r1;
  assign r2_s         = bus.r2;
  assign fall_pc      = bus.pc + 32'd4;
  assign is_br        = bus.jal | bus.jalr | bus.beq | bus.bne | bus.bge;
  assign unused_if_pc = bus.if_pc[1:0];

  // Resolve: type priority jalr > jal > bge > bne > beq
  always_comb begin
    taken  = 1'b0;
    target = bus.pc + (bus.imm_B << 1);
    if (bus.jalr) begin
      taken  = 1'b1;
      target = (bus.r1 + bus.imm_I_S) & ~32'd1;
    end else if (bus.jal) begin
      taken  = 1'b1;
      target = bus.pc + (bus.imm_J << 1);
    end else if (bus.bge) begin
      taken = (r1_s >= r2_s);
    end else if (bus.bne) begin
      taken = (bus.r1 != bus.r2);
    end else if (bus.beq) begin
      taken = (bus.r1 == bus.r2);
    end
  end

  // jalr is never predicted, so it always redirects when it advances
  always_comb begin
    bus.redirect = 1'b0;
    if (!rst && bus.en && is_br)
      bus.redirect = bus.jalr ? 1'b1 : (taken != bus.predict_jump);
    bus.redirect_pc = (bus.redirect && taken) ? target : fall_pc;
  end

  assign if_idx            = bus.if_pc[BTB_IDX_W+1:2];
  assign if_tag            = bus.if_pc[31:BTB_IDX_W+2];
  assign if_hit            = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign bus.if_predict    = if_hit && btb_ctr[if_idx][1];
  assign bus.if_predict_pc = if_hit ? btb_target[if_idx] : 32'd0;

  assign exe_idx = bus.pc[BTB_IDX_W+1:2];
  assign exe_tag = bus.pc[31:BTB_IDX_W+2];
  assign exe_hit = btb_valid[exe_idx] && (btb_tag[exe_idx] == exe_tag);
  assign upd     = bus.en && !rst && !bus.jalr && (bus.jal | bus.beq | bus.bne | bus.bge);

  // BTB control state: valid bits and saturating direction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_ctr[i]   <= 2'b00;
      end
    end else if (upd) begin
      if (exe_hit) begin
        btb_ctr[exe_idx] <= ctr_step(btb_ctr[exe_idx], taken);
      end else if (taken) begin
        btb_valid[exe_idx] <= 1'b1;
        btb_ctr[exe_idx]   <= 2'b10;
      end
    end
  end

  // BTB payload needs no reset: it is only observed through a valid entry
  always_ff @(posedge clk) begin
    if (upd && (exe_hit || taken)) begin
      btb_tag[exe_idx]    <= exe_tag;
      btb_target[exe_idx] <= target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (bus.en) begin
      if (is_br)        branch_cnt     <= sat_inc(branch_cnt);
      if (bus.redirect) mispredict_cnt <= sat_inc(mispredict_cnt);
    end
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EXE-stage consumer of the ID/EXE control-flow fields: jal/jalr/beq/bne/bge, predict_jump, pc, immediates and forwarded operands.
- Resolves the actual branch outcome and target, detects mispredictions, and drives redirect/flush back to IF/ID and ID/EXE.
- Owns the branch target buffer with 2-bit counters that produces predict_jump at fetch, so it closes the predict→resolve loop.

Parameters:
- BTB_IDX_W, 4, index bits; BTB has 2^BTB_IDX_W entries, indexed by pc[BTB_IDX_W+1:2].
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  pipeline advance; same enable as ID/EXE; 0 = stall
- pc  in  32  EXE instruction pc
- jal, jalr, beq, bne, bge  in  1 each  EXE control-flow type; all 0 = non-branch or bubble
- predict_jump  in  1  prediction carried down the pipe for this instruction
- r1, r2  in  32  forwarded operands
- imm_I_S, imm_B, imm_J  in  32  sign-extended, unshifted immediates
- redirect  out  1  flush request to IF/ID and ID/EXE; PC mux select
- redirect_pc  out  32  corrected fetch pc
- if_pc  in  32  fetch pc for lookup
- if_predict  out  1  predicted taken at fetch
- if_predict_pc  out  32  predicted target
- branch_cnt  out  CNT_W  resolved control-flow instructions
- mispredict_cnt  out  CNT_W  redirects issued

Behaviour:
- Type priority if several bits are set (illegal): jalr > jal > bge > bne > beq.
- Taken:
  - beq: r1==r2.
  - bne: r1!=r2.
  - bge: signed r1>=r2.
  - jal/jalr: always taken.
- Targets, 32-bit wrap-around adds:
  - B-type: pc + {imm_B[30:0],1'b0}.
  - jal: pc + {imm_J[30:0],1'b0}.
  - jalr: (r1 + imm_I_S) & ~1.
- Redirect (combinational):
  - jalr: redirect = en, always, since jalr is never predicted.
  - Others: redirect = en & (taken != predict_jump).
  - redirect_pc = taken ? target : pc+4.
  - redirect = 0 while rst or bubble. redirect_pc is don't-care when redirect=0 and is driven pc+4.
- BTB entry fields: valid, tag = pc[31:BTB_IDX_W+2], target[31:0], ctr[1:0].
- Lookup (combinational on if_pc):
  - if_predict = valid & tag match & ctr[1].
  - if_predict_pc = entry target, or 0 on miss.
- Update at posedge, only when en & ~rst & (jal|beq|bne|bge):
  - Hit: ctr saturating +1 if taken, −1 if not (00 and 11 saturate); target rewritten.
  - Miss & taken: allocate, overwriting the slot: valid=1, tag, target, ctr=2'b10.
  - Miss & not taken: no change.
  - jalr never updates the BTB.
- Same-cycle lookup and update of one entry: lookup returns the pre-update value. The new value is visible the next cycle.
- Counters, updated at posedge when en & ~rst:
  - branch_cnt +1 on any of the five types.
  - mispredict_cnt +1 when redirect=1.
  - Both saturate at all-ones and never wrap.
- en=0: no BTB or counter update; redirect=0. The held instruction resolves once, when en returns to 1.
- Reset (synchronous):
  - All valid bits, counters and ctr fields cleared.
  - Outputs after reset: if_predict=0, if_predict_pc=0, redirect=0, branch_cnt=0, mispredict_cnt=0.
  - Reset asserted mid-stream discards any pending update in that cycle.
- Latency: resolution 0 cycles (combinational); training visible at fetch 1 cycle after the resolving edge.

Test Plan:
- Reset, then lookup if_pc=0x40 and 0x1000 → if_predict=0, if_predict_pc=0; counters 0.
- beq at pc=0x40, r1=r2=5, imm_B=0x8, predict_jump=0, en=1 → redirect=1, redirect_pc=0x50. Next cycle: lookup 0x40 gives if_predict=1, if_predict_pc=0x50; branch_cnt=1, mispredict_cnt=1.
- Same entry, bne at 0x40, r1=r2 (not taken):
  - First: predict_jump=1 → redirect=1, redirect_pc=0x44; ctr 10→01, if_predict=0.
  - Second: predict_jump=0 → redirect=0; ctr 01→00, counts 3/2.
- bge pc=0x80, r1=0xFFFFFFFF, r2=1, predict_jump=0 → not taken, redirect=0, no allocation. With r1=1, r2=0xFFFFFFFF → redirect=1, redirect_pc=0x80+target.
- jalr r1=0x101, imm_I_S=2, predict_jump=1 → redirect=1, redirect_pc=0x102; BTB lookup of pc unchanged.
- Mispredicting beq held with en=0 for 3 cycles → redirect=0, counters frozen; en=1 → single redirect, mispredict_cnt +1. rst pulse in the same cycle → no update, all state cleared.
